// File: rtl/des_pkg.sv
// Shared DES definitions: block/half widths, IP and FP index tables, and the
// pure permutation function used by the permutation pipe (and reused by the
// round and key-schedule blocks). Bit numbering follows DES: bit 1 = MSB.
package des_pkg;

    localparam int DES_BLK_W  = 64;
    localparam int DES_HALF_W = 32;

    typedef enum logic {
        PERM_IP = 1'b0,
        PERM_FP = 1'b1
    } perm_mode_e;

    // Source bit index for each output bit (entry 0 -> output bit 1).
    localparam int IP_TBL [DES_BLK_W] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int FP_TBL [DES_BLK_W] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
    };

    // IP when mode=PERM_IP (swap ignored); FP when mode=PERM_FP, optionally
    // after exchanging halves so R16||L16 from the last round lands correctly.
    function automatic logic [1:DES_BLK_W] des_permute(
        input logic [1:DES_BLK_W] data,
        input logic               mode,
        input logic               swap
    );
        logic [1:DES_BLK_W] d;
        logic [1:DES_BLK_W] p;
        d = data;
        if (mode == PERM_FP && swap)
            d = {data[DES_HALF_W+1:DES_BLK_W], data[1:DES_HALF_W]};
        for (int i = 0; i < DES_BLK_W; i++)
            p[i+1] = (mode == PERM_FP) ? d[FP_TBL[i]] : d[IP_TBL[i]];
        return p;
    endfunction

endpackage

// File: rtl/des_pipe_stage.sv
// One pipeline register: valid bit, 64-bit block and sideband tag.
// Latency: 1 cycle; loads on load, holds otherwise.
// Backpressure: none internally; the parent derives load from downstream.
// Ports: clk, rst (sync, active-high), load, nxt_valid/nxt_data/nxt_tag (next
// contents), valid/data/tag (registered contents).
module des_pipe_stage
    import des_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 nxt_valid,
    input  logic [1:DES_BLK_W]   nxt_data,
    input  logic [TAG_W-1:0]     nxt_tag,
    output logic                 valid,
    output logic [1:DES_BLK_W]   data,
    output logic [TAG_W-1:0]     tag
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            tag   <= '0;
        end else if (load) begin
            valid <= nxt_valid;
            // Bubbles only clear the valid bit; payload keeps its last value.
            if (nxt_valid) begin
                data <= nxt_data;
                tag  <= nxt_tag;
            end
        end
    end

endmodule

// File: rtl/des_perm_pipe.sv
// DES IP / FP(IP^-1) permutation with optional pre-FP half swap, valid/ready pipe.
// Latency: PIPE_STAGES cycles, 1 word/cycle throughput.
// Backpressure: bubble-collapsing; in_ready drops only when every stage is full and out_ready=0.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_mode/in_swap/in_data/in_tag
// upstream; out_valid/out_ready/out_l/out_r/out_tag downstream; busy = any stage valid.
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic                  in_swap,
    input  logic [1:DES_BLK_W]    in_data,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:DES_HALF_W]   out_l,
    output logic [1:DES_HALF_W]   out_r,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  busy
);

    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
        $error("des_perm_pipe: PIPE_STAGES must be in 1..4");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("des_perm_pipe: TAG_W must be >= 1");
    end

    logic [1:PIPE_STAGES]  v;
    logic [1:PIPE_STAGES]  ld;
    logic [1:DES_BLK_W]    sd [1:PIPE_STAGES];
    logic [TAG_W-1:0]      st [1:PIPE_STAGES];
    logic [1:DES_BLK_W]    perm;

    assign perm = des_permute(in_data, in_mode, in_swap);

    // Stage k may load if downstream drains this cycle or any stage from k to
    // the output holds a bubble; unrolled so no signal feeds back on itself.
    always_comb begin
        for (int k = 1; k <= PIPE_STAGES; k++) begin
            ld[k] = out_ready;
            for (int j = k; j <= PIPE_STAGES; j++)
                if (!v[j]) ld[k] = 1'b1;
        end
    end

    for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_stage
        logic                nv;
        logic [1:DES_BLK_W]  nd;
        logic [TAG_W-1:0]    nt;

        if (k == 1) begin : g_head
            assign nv = in_valid;
            assign nd = perm;
            assign nt = in_tag;
        end else begin : g_body
            assign nv = v[k-1];
            assign nd = sd[k-1];
            assign nt = st[k-1];
        end

        des_pipe_stage #(.TAG_W(TAG_W)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .load      (ld[k]),
            .nxt_valid (nv),
            .nxt_data  (nd),
            .nxt_tag   (nt),
            .valid     (v[k]),
            .data      (sd[k]),
            .tag       (st[k])
        );
    end

    assign in_ready  = ld[1];
    assign out_valid = v[PIPE_STAGES];
    assign out_l     = sd[PIPE_STAGES][1:DES_HALF_W];
    assign out_r     = sd[PIPE_STAGES][DES_HALF_W+1:DES_BLK_W];
    assign out_tag   = st[PIPE_STAGES];
    assign busy      = |v;

endmodule
